graph_loader: RTL
=================

// Module: graph_loader
// PURPOSE
// - Writer side of the Graph Memory consumed by the bellmanford engine: takes an edge stream (u,v,w),
//   packs it into 128-bit adjacency records and writes the header plus one record per node.
// - Sits between the host/testbench edge source and the Graph Memory write port.
// - Runs before bellmanford is started; the two never access Graph Memory concurrently.
// PARAMETERS
// - ADDR_W     13   Graph Memory address width
// - DATA_W     128  Graph Memory word width
// - NODE_W     8    node id / weight width
// - MAX_LINKS  7    (V,W) slots per adjacency record
// PORTS
// - clock       in   1    single clock, rising edge
// - reset       in   1    asynchronous, active-high
// - start       in   1    one-cycle pulse in IDLE; begins a load
// - num_nodes   in   8    node count N, sampled on start
// - edge_valid  in   1    edge beat valid
// - edge_ready  out  1    edge beat accepted when valid&&ready
// - edge_u      in   8    source node id
// - edge_v      in   8    destination node id
// - edge_w      in   8    signed weight
// - edge_last   in   1    final edge of the stream
// - GMWAR       out  13   Graph Memory write address
// - GMWDR       out  128  Graph Memory write data
// - GMWE        out  1    Graph Memory write enable, one cycle per word
// - busy        out  1    high from start until DONE or ERR
// - done        out  1    one-cycle pulse, load complete
// - err         out  1    sticky until next start
// - err_code    out  2    1=overflow (>7 links), 2=order (u decreased), 3=range (0 or >N)
// BEHAVIOUR
// - Reset: every output 0, state IDLE, all counters and the buffer cleared. Reset mid-load aborts at once;
//   words already written stay in memory and no clean-up is done.
// - All outputs are registered except edge_ready, which is combinational from state, edge_valid and edge_u.
//   A write issues one cycle after the decision that triggers it.
// - Header: address 0, data = {64'b0, 56'b0, N}.
// - Record for node u: address u.
//   - [127:120]=u, [119:112]=link count.
//   - Slot k (0..6): V at [111-16k -:8], W at [103-16k -:8].
//   - Unused slots are 0.
// - States:
//   - IDLE: wait for start. If N==0 -> ERR(3). Otherwise -> HDR.
//   - HDR: write the header, cur=1, cnt=0 -> COLLECT.
//   - COLLECT: edge_ready = !(edge_valid && edge_u!=cur). On a beat with u==cur:
//     - v==0 or v>N -> ERR(3).
//     - cnt==7 -> ERR(overflow).
//     - Otherwise store (v,w) in slot cnt and cnt++.
//     - Accepted beat with edge_last -> FLUSH_END.
//   - COLLECT, valid beat with u!=cur, not accepted:
//     - cur<u<=N -> FLUSH.
//     - u<cur -> ERR(2).
//     - u==0 or u>N -> ERR(3).
//   - FLUSH: write record cur, clear buffer, cur++ -> COLLECT. This repeats until cur==u, which emits
//     empty records for skipped nodes.
//   - FLUSH_END: write record cur. cur==N -> DONE; else cur++ and -> FILL.
//   - FILL: write an empty record each cycle until node N is written -> DONE.
//   - DONE: done=1 and busy=0 for one cycle -> IDLE.
//   - ERR: err=1 with err_code held, GMWE=0, edge_ready=0. Leaves only on start (clears err) or on reset.
// - start outside IDLE/ERR is ignored.
// - Edges must arrive grouped by u, ascending. Duplicate (u,v) pairs are stored as given.
// - Total writes for a clean load = N+1.
// - Throughput: 1 edge/cycle, plus 1 cycle per record flush.
// - Weight is passed through as 8-bit two's complement and never altered.
// STRUCTURE
// - Shared package gl_pkg: state enum, err_code constants, a record pack function, header constant layout.
//   bellmanford reuses the same field offsets.
// - One natural sub-module, adj_record_buf: 7-slot buffer with append, clear and pack-to-128 (count, full flag).
// - FSM and address counter stay in the top level.
// TESTING
// - N=3; edges (1,2,5),(1,3,-2),(2,3,1,last) -> writes:
//   - @0 hdr=3
//   - @1 {01,02,02,05,03,FE,0..}
//   - @2 {02,01,03,01,0..}
//   - @3 {03,00,0..}
//   - then done.
// - N=5; only edge (4,1,7,last) -> @1..@3 empty records, @4 count=1, @5 empty; 6 writes total.
// - 8 edges with u=2 -> 8th beat gives err=1, err_code=1, GMWE stays 0 afterwards, edge_ready=0.
// - Edges u=3 then u=2 -> err_code=2; edge v=9 with N=4 -> err_code=3.
// - Random edge_valid gaps plus reset asserted during FILL:
//   - all outputs 0 immediately;
//   - the next start completes a fresh load correctly.
// - start with N=0 -> err_code=3, no writes.

Source files
------------

// File: rtl/gl_pkg.sv
// Shared Graph Memory layout: FSM states, error codes, header and record packing.
package gl_pkg;

    localparam int unsigned GL_NODE_W      = 8;
    localparam int unsigned GL_DATA_W      = 128;
    localparam int unsigned GL_MAX_LINKS   = 7;
    localparam int unsigned GL_SLOT_W      = 16;
    localparam int unsigned GL_ID_MSB      = 127;
    localparam int unsigned GL_CNT_MSB     = 119;
    localparam int unsigned GL_SLOT0_V_MSB = 111;
    localparam int unsigned GL_SLOT0_W_MSB = 103;

    localparam logic [1:0] GL_ERR_NONE     = 2'd0;
    localparam logic [1:0] GL_ERR_OVERFLOW = 2'd1;
    localparam logic [1:0] GL_ERR_ORDER    = 2'd2;
    localparam logic [1:0] GL_ERR_RANGE    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_COLLECT,
        S_FLUSH,
        S_FLUSH_END,
        S_FILL,
        S_DONE,
        S_ERR
    } gl_state_e;

    typedef logic [GL_MAX_LINKS-1:0][GL_NODE_W-1:0] gl_slots_t;

    // Header word at address 0: node count in the low byte, rest zero.
    function automatic logic [GL_DATA_W-1:0] gl_pack_header(input logic [GL_NODE_W-1:0] n);
        return {{(GL_DATA_W-GL_NODE_W){1'b0}}, n};
    endfunction

    // Adjacency record: node id, link count, then (V,W) byte pairs from the top down.
    function automatic logic [GL_DATA_W-1:0] gl_pack_record(
        input logic [GL_NODE_W-1:0] node,
        input logic [GL_NODE_W-1:0] cnt,
        input gl_slots_t            v,
        input gl_slots_t            w
    );
        logic [GL_DATA_W-1:0] r;
        r = '0;
        r[GL_ID_MSB  -: GL_NODE_W] = node;
        r[GL_CNT_MSB -: GL_NODE_W] = cnt;
        for (int unsigned k = 0; k < GL_MAX_LINKS; k++) begin
            r[GL_SLOT0_V_MSB - GL_SLOT_W*k -: GL_NODE_W] = v[k];
            r[GL_SLOT0_W_MSB - GL_SLOT_W*k -: GL_NODE_W] = w[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/graph_loader_adj_record_buf.sv
// Seven-slot (V,W) buffer for one node's adjacency record.
module adj_record_buf
    import gl_pkg::*;
#(
    parameter int unsigned MAX_LINKS = GL_MAX_LINKS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_append,
    input  logic [GL_NODE_W-1:0] i_v,
    input  logic [GL_NODE_W-1:0] i_w,
    input  logic [GL_NODE_W-1:0] i_node,
    output logic                 o_full,
    output logic [GL_DATA_W-1:0] o_record
);

    logic [2:0] r_count;
    gl_slots_t  r_v;
    gl_slots_t  r_w;

    assign o_full   = (r_count == 3'(MAX_LINKS));
    assign o_record = gl_pack_record(i_node, {5'b0, r_count}, r_v, r_w);

    // Slot storage: clear wipes every slot so unused slots pack as zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_v     <= '0;
            r_w     <= '0;
        end else if (i_clear) begin
            r_count <= '0;
            r_v     <= '0;
            r_w     <= '0;
        end else if (i_append && !o_full) begin
            r_v[r_count] <= i_v;
            r_w[r_count] <= i_w;
            r_count      <= r_count + 3'd1;
        end
    end

endmodule

// File: rtl/graph_loader.sv
// Edge-stream to Graph Memory loader: header plus one adjacency record per node.
module graph_loader
    import gl_pkg::*;
#(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned NODE_W    = 8,
    parameter int unsigned MAX_LINKS = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [NODE_W-1:0] num_nodes,
    input  logic              edge_valid,
    output logic              edge_ready,
    input  logic [NODE_W-1:0] edge_u,
    input  logic [NODE_W-1:0] edge_v,
    input  logic [NODE_W-1:0] edge_w,
    input  logic              edge_last,
    output logic [ADDR_W-1:0] GMWAR,
    output logic [DATA_W-1:0] GMWDR,
    output logic              GMWE,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    gl_state_e         r_state, w_next;
    logic [NODE_W-1:0] r_cur, w_cur_next;
    logic [NODE_W-1:0] r_n, w_n_next;
    logic [1:0]        w_ecode;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_clear;
    logic              w_append;
    logic              w_full;
    logic [DATA_W-1:0] w_record;

    adj_record_buf #(
        .MAX_LINKS (MAX_LINKS)
    ) u_buf (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_append (w_append),
        .i_v      (edge_v),
        .i_w      (edge_w),
        .i_node   (r_cur),
        .o_full   (w_full),
        .o_record (w_record)
    );

    // Next-state, buffer control, pending write and edge handshake.
    always_comb begin
        w_next     = r_state;
        w_cur_next = r_cur;
        w_n_next   = r_n;
        w_ecode    = GL_ERR_NONE;
        w_we       = 1'b0;
        w_addr     = '0;
        w_data     = '0;
        w_clear    = 1'b0;
        w_append   = 1'b0;
        edge_ready = 1'b0;
        case (r_state)
            S_IDLE, S_ERR: begin
                if (r_state == S_ERR) w_ecode = err_code;
                if (start) begin
                    w_n_next = num_nodes;
                    if (num_nodes == '0) begin
                        w_next  = S_ERR;
                        w_ecode = GL_ERR_RANGE;
                    end else begin
                        w_next  = S_HDR;
                    end
                end
            end
            S_HDR: begin
                w_we       = 1'b1;
                w_data     = gl_pack_header(r_n);
                w_clear    = 1'b1;
                w_cur_next = NODE_W'(1);
                w_next     = S_COLLECT;
            end
            S_COLLECT: begin
                edge_ready = !(edge_valid && edge_u != r_cur);
                if (edge_valid) begin
                    if (edge_u == r_cur) begin
                        if (edge_v == '0 || edge_v > r_n) begin
                            w_next  = S_ERR;
                            w_ecode = GL_ERR_RANGE;
                        end else if (w_full) begin
                            w_next  = S_ERR;
                            w_ecode = GL_ERR_OVERFLOW;
                        end else begin
                            w_append = 1'b1;
                            if (edge_last) w_next = S_FLUSH_END;
                        end
                    end else if (edge_u == '0 || edge_u > r_n) begin
                        w_next  = S_ERR;
                        w_ecode = GL_ERR_RANGE;
                    end else if (edge_u < r_cur) begin
                        w_next  = S_ERR;
                        w_ecode = GL_ERR_ORDER;
                    end else begin
                        w_next  = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                w_we       = 1'b1;
                w_addr     = ADDR_W'(r_cur);
                w_data     = w_record;
                w_clear    = 1'b1;
                w_cur_next = r_cur + NODE_W'(1);
                w_next     = S_COLLECT;
            end
            S_FLUSH_END, S_FILL: begin
                // The buffer is cleared after the last real record, so FILL packs empty records.
                w_we    = 1'b1;
                w_addr  = ADDR_W'(r_cur);
                w_data  = w_record;
                w_clear = 1'b1;
                if (r_cur == r_n) begin
                    w_next = S_DONE;
                end else begin
                    w_cur_next = r_cur + NODE_W'(1);
                    w_next     = S_FILL;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; every write lands one cycle after its decision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cur    <= '0;
            r_n      <= '0;
            GMWE     <= 1'b0;
            GMWAR    <= '0;
            GMWDR    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= '0;
        end else begin
            r_state  <= w_next;
            r_cur    <= w_cur_next;
            r_n      <= w_n_next;
            GMWE     <= w_we;
            GMWAR    <= w_addr;
            GMWDR    <= w_data;
            busy     <= (w_next == S_HDR) || (w_next == S_COLLECT) || (w_next == S_FLUSH) ||
                        (w_next == S_FLUSH_END) || (w_next == S_FILL);
            done     <= (w_next == S_DONE);
            err      <= (w_next == S_ERR);
            err_code <= (w_next == S_ERR) ? w_ecode : GL_ERR_NONE;
        end
    end

endmodule
